// File: rtl/key_load_ctrl_pkg.sv
// key_ctrl_pkg: shared types and constants for the key load controller.
//   key_state_t     - controller FSM states
//   KEY_IDX_W       - key word index width
//   WDOG_W          - FETCH watchdog width (KEY_TIMEOUT_EN builds)
//   TIMEOUT_CYC_DEF - default watchdog limit
//   DATA_W_DEF      - default key word width
package key_ctrl_pkg;

    localparam int unsigned KEY_IDX_W       = 2;
    localparam int unsigned WDOG_W          = 8;
    localparam int unsigned TIMEOUT_CYC_DEF = 255;
    localparam int unsigned DATA_W_DEF      = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        READY = 3'd3,
        RUN   = 3'd4
    } key_state_t;

endpackage

// File: rtl/key_load_ctrl_if.sv
// key_load_ctrl_if: host key FIFO, key register file and cipher handshake
// signals of the key load controller.
//   master - controller side: pops FIFO, writes key words, grants jobs
//   slave  - environment side: FIFO, key register file, job requester, cipher
interface key_load_ctrl_if
    import key_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic                 load_req;
    logic                 key_clear;
    logic                 fifo_empty;
    logic [DATA_W-1:0]    fifo_rdata;
    logic                 fifo_rd;
    logic                 key_wr_en;
    logic [KEY_IDX_W-1:0] key_sel;
    logic [DATA_W-1:0]    key_wdata;
    logic                 key_valid;
    logic                 enc_req;
    logic                 enc_gnt;
    logic                 cipher_start;
    logic                 cipher_done;
    logic                 key_err;

    modport master (
        input  load_req, key_clear, fifo_empty, fifo_rdata, enc_req, cipher_done,
        output fifo_rd, key_wr_en, key_sel, key_wdata, key_valid, enc_gnt,
               cipher_start, key_err
    );

    modport slave (
        output load_req, key_clear, fifo_empty, fifo_rdata, enc_req, cipher_done,
        input  fifo_rd, key_wr_en, key_sel, key_wdata, key_valid, enc_gnt,
               cipher_start, key_err
    );

endinterface

// File: rtl/key_load_ctrl_word_idx.sv
// key_word_idx: key word index counter for the load sequence.
//   clk, rst - clock, synchronous active-high reset
//   clear_i  - return index to 0 (wins over incr_i)
//   incr_i   - advance to next word, wrapping after the last one
//   idx_o    - current word index
//   last_o   - index is at the final key word (KEY_WORDS-1)
module key_word_idx
    import key_ctrl_pkg::*;
#(
    parameter int unsigned KEY_WORDS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 incr_i,
    output logic [KEY_IDX_W-1:0] idx_o,
    output logic                 last_o
);

    logic [KEY_IDX_W-1:0] idx_q, idx_d;

    assign idx_o  = idx_q;
    assign last_o = (idx_q == KEY_IDX_W'(KEY_WORDS - 1));

    // Wrap on the last word so the index never exceeds KEY_WORDS-1.
    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (incr_i) begin
            idx_d = last_o ? '0 : idx_q + KEY_IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/key_load_ctrl.sv
// key_load_ctrl: loads a KEY_WORDS-word key from the host key FIFO into the
// cipher key register file, then grants encryption jobs against that key.
//   clk, rst - clock, synchronous active-high reset
//   bus      - key_load_ctrl_if.master: FIFO pop, key write, job handshake
// Optional build macro KEY_TIMEOUT_EN adds an empty-FIFO watchdog in FETCH
// that aborts the load and raises the sticky key_err flag.
module key_load_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int unsigned KEY_WORDS   = 3,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    key_load_ctrl_if.master bus
);

    // Elaboration-time range checks on the configuration.
    if (KEY_WORDS < 2 || KEY_WORDS > 4) begin : g_bad_key_words
        $error("key_load_ctrl: KEY_WORDS must be 2..4");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("key_load_ctrl: TIMEOUT_CYC must be 1..255");
    end

    key_state_t           state_q, state_d;
    logic                 idx_clr_c;
    logic                 idx_inc_c;
    logic                 grant_c;
    logic [KEY_IDX_W-1:0] idx;
    logic                 idx_last;
    logic [DATA_W-1:0]    wdata_c;

    key_word_idx #(
        .KEY_WORDS (KEY_WORDS)
    ) u_idx (
        .clk     (clk),
        .rst     (rst),
        .clear_i (idx_clr_c),
        .incr_i  (idx_inc_c),
        .idx_o   (idx),
        .last_o  (idx_last)
    );

`ifdef KEY_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              timeout_c;

    // Fires on the TIMEOUT_CYC-th consecutive-count empty FETCH cycle.
    assign timeout_c = (state_q == FETCH) && bus.fifo_empty &&
                       (wdog_q == WDOG_W'(TIMEOUT_CYC - 1));

    // Held at 0 outside FETCH, so every entry into FETCH starts from 0.
    always_comb begin
        wdog_d = '0;
        if (state_q == FETCH) begin
            wdog_d = bus.fifo_empty ? wdog_q + WDOG_W'(1) : wdog_q;
        end
    end

    // Sticky error: set by a timeout, cleared only by an accepted load.
    always_comb begin
        err_d = err_q;
        if (!bus.key_clear) begin
            if (state_q == IDLE && bus.load_req) begin
                err_d = 1'b0;
            end else if (timeout_c) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign bus.key_err = err_q;
`else
    assign bus.key_err = 1'b0;
`endif

    // Next-state, index control and the Mealy job grant.
    always_comb begin
        state_d   = state_q;
        idx_clr_c = 1'b0;
        idx_inc_c = 1'b0;
        grant_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.load_req) begin
                    state_d   = FETCH;
                    idx_clr_c = 1'b1;
                end
            end
            FETCH: begin
                if (!bus.fifo_empty) begin
                    state_d = LOAD;
`ifdef KEY_TIMEOUT_EN
                end else if (timeout_c) begin
                    state_d   = IDLE;
                    idx_clr_c = 1'b1;
`endif
                end
            end
            LOAD: begin
                if (idx_last) begin
                    state_d   = READY;
                    idx_clr_c = 1'b1;
                end else begin
                    state_d   = FETCH;
                    idx_inc_c = 1'b1;
                end
            end
            READY: begin
                if (bus.load_req) begin
                    state_d   = FETCH;
                    idx_clr_c = 1'b1;
                end else if (bus.enc_req) begin
                    state_d = RUN;
                    grant_c = 1'b1;
                end
            end
            RUN: begin
                // A reload abandons the job; its cipher_done arrives outside RUN.
                if (bus.load_req) begin
                    state_d   = FETCH;
                    idx_clr_c = 1'b1;
                end else if (bus.cipher_done) begin
                    state_d = READY;
                end
            end
            default: begin
                state_d   = IDLE;
                idx_clr_c = 1'b1;
            end
        endcase

        // Clear outranks every other request in every state.
        if (bus.key_clear) begin
            state_d   = IDLE;
            idx_clr_c = 1'b1;
            idx_inc_c = 1'b0;
            grant_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pop is combinational on the empty flag so a word moves every two cycles.
    assign bus.fifo_rd      = (state_q == FETCH) && !bus.fifo_empty;
    assign bus.key_wr_en    = (state_q == LOAD);
    assign bus.key_sel      = (state_q == LOAD) ? idx : '0;
    assign wdata_c          = (state_q == LOAD) ? bus.fifo_rdata : '0;
    assign bus.key_wdata    = wdata_c;
    assign bus.key_valid    = (state_q == READY) || (state_q == RUN);
    assign bus.enc_gnt      = grant_c;
    assign bus.cipher_start = grant_c;

endmodule
